multi_lane_bit_packer: RTL and testbench

//  Sequential successor to the two-word pack/shift datapath of the compressor. Merges LANES variable-length

---
 rtl/multi_lane_bit_packer_pkg.sv | 17 +
 rtl/multi_lane_bit_packer_token_merger.sv | 33 +++
 rtl/multi_lane_bit_packer.sv | 94 +++++++++
 tb/tb_multi_lane_bit_packer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/multi_lane_bit_packer_pkg.sv
// multi_lane_bit_packer_pkg: FSM state constants and width/length helpers shared by the bit packer
package multi_lane_bit_packer_pkg;
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  function automatic int buf_w(input int cache_line, input int lanes, input int tok_max);
    return cache_line - 1 + lanes * tok_max;
  endfunction
  function automatic int len_w(input int tok_max);
    return $clog2(tok_max + 1);
  endfunction
  function automatic int cnt_w(input int line_words, input int tok_max);
    return $clog2(line_words * tok_max + 1);
  endfunction
  function automatic int clamp_len(input int len, input int tok_max);
    return len > tok_max ? tok_max : len;
  endfunction
endpackage

// File: rtl/multi_lane_bit_packer_token_merger.sv
// multi_lane_bit_packer_token_merger: concatenates LANES tokens MSB-first into one vector plus total length
//   tok_data_i  LANES right-aligned tokens, lane 0 first in stream
//   tok_len_i   per-lane lengths, clamped to TOK_MAX, 0 = empty lane
//   merged_o    gap-free MSB-aligned concatenation, zero below total_o bits
//   total_o     sum of clamped lengths
module multi_lane_bit_packer_token_merger
  import multi_lane_bit_packer_pkg::*;
#(
  parameter int LANES = 2,
  parameter int TOK_MAX = 34,
  localparam int LEN_W = len_w(TOK_MAX),
  localparam int MW = LANES * TOK_MAX,
  localparam int SW = $clog2(MW + 1)
) (
  input  logic [LANES*TOK_MAX-1:0] tok_data_i,
  input  logic [LANES*LEN_W-1:0]   tok_len_i,
  output logic [MW-1:0]            merged_o,
  output logic [SW-1:0]            total_o
);
  always_comb begin
    int tot;
    int l;
    merged_o = '0;
    tot = 0;
    l = 0;
    for (int k = 0; k < LANES; k++) begin
      l = clamp_len(int'(tok_len_i[k*LEN_W +: LEN_W]), TOK_MAX);
      merged_o = merged_o | (MW'(tok_data_i[k*TOK_MAX +: TOK_MAX] & ({TOK_MAX{1'b1}} >> (TOK_MAX - l))) << (MW - tot - l));
      tot = tot + l;
    end
    total_o = SW'(tot);
  end
endmodule

// File: rtl/multi_lane_bit_packer.sv
// multi_lane_bit_packer: packs LANES variable-length tokens per beat into CACHE_LINE-bit chunks, flushing per line
//   i_clk, i_rst_n                     clock, synchronous active-low reset
//   i_valid/o_ready                    input beat handshake; i_tok_data/i_tok_len per lane, i_last closes line
//   o_valid/i_ready                    output chunk handshake
//   o_data, o_bits, o_last             MSB-aligned chunk, its valid bit count, final chunk of line
//   o_line_bits, o_incompressible      line totals, meaningful with o_last
//   PACKER_INCOMPRESSIBLE_EN           when defined, o_incompressible flags lines larger than raw size
module multi_lane_bit_packer
  import multi_lane_bit_packer_pkg::*;
#(
  parameter int LANES = 2,
  parameter int TOK_MAX = 34,
  parameter int CACHE_LINE = 64,
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WORDS = 16,
  localparam int LEN_W = len_w(TOK_MAX),
  localparam int OBW = $clog2(CACHE_LINE + 1),
  localparam int CW = cnt_w(LINE_WORDS, TOK_MAX)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [LANES*TOK_MAX-1:0] i_tok_data,
  input  logic [LANES*LEN_W-1:0]   i_tok_len,
  input  logic                     i_last,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [CACHE_LINE-1:0]    o_data,
  output logic [OBW-1:0]           o_bits,
  output logic                     o_last,
  output logic [CW-1:0]            o_line_bits,
  output logic                     o_incompressible
);
  localparam int MW = LANES * TOK_MAX;
  localparam int SW = $clog2(MW + 1);
  localparam int BW = buf_w(CACHE_LINE, LANES, TOK_MAX);
  localparam int FW = $clog2(BW + 1);
  localparam logic [FW-1:0] CL_F = FW'(CACHE_LINE);
  localparam logic [CW-1:0] CNT_MAX = '1;
  logic [MW-1:0] merged;
  logic [SW-1:0] total;
  logic [BW-1:0] acc_q, acc_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [CW-1:0] line_q, line_d;
  logic [0:0] st_q, st_d;
  logic live_q;
  logic accept, pop, last_chunk;
  logic [CW:0] line_sum;
  multi_lane_bit_packer_token_merger #(.LANES(LANES), .TOK_MAX(TOK_MAX)) u_merger (
    .tok_data_i(i_tok_data),
    .tok_len_i (i_tok_len),
    .merged_o  (merged),
    .total_o   (total)
  );
  // ready is gated by live_q so it stays low through reset and rises the cycle after release
  assign o_ready = live_q && st_q == RUN && fill_q < CL_F;
  assign o_valid = fill_q >= CL_F || st_q == FLUSH;
  assign last_chunk = st_q == FLUSH && fill_q <= CL_F;
  assign accept = i_valid && o_ready;
  assign pop = o_valid && i_ready;
  assign line_sum = {1'b0, line_q} + (CW+1)'(total);
  // bits below fill are always zero, so appending is an OR of the merged vector shifted under the fill
  always_comb begin
    acc_d = accept ? acc_q | ({merged, {(CACHE_LINE-1){1'b0}}} >> fill_q) : pop && !last_chunk ? acc_q << CACHE_LINE : pop ? '0 : acc_q;
    fill_d = accept ? fill_q + FW'(total) : pop && !last_chunk ? fill_q - CL_F : pop ? '0 : fill_q;
    line_d = accept ? (line_sum > {1'b0, CNT_MAX} ? CNT_MAX : line_sum[CW-1:0]) : pop && last_chunk ? '0 : line_q;
    st_d = accept && i_last ? FLUSH : pop && last_chunk ? RUN : st_q;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc_q <= '0;
      fill_q <= '0;
      line_q <= '0;
      st_q <= RUN;
      live_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      fill_q <= fill_d;
      line_q <= line_d;
      st_q <= st_d;
      live_q <= 1'b1;
    end
  end
  assign o_data = acc_q[BW-1 -: CACHE_LINE];
  assign o_bits = !o_valid ? '0 : last_chunk ? OBW'(fill_q) : OBW'(CACHE_LINE);
  assign o_last = last_chunk;
  assign o_line_bits = last_chunk ? line_q : '0;
`ifdef PACKER_INCOMPRESSIBLE_EN
  assign o_incompressible = last_chunk && (32'(line_q) > 32'(LINE_WORDS * WORD_WIDTH));
`else
  assign o_incompressible = 1'b0;
`endif
endmodule

// File: tb/tb_multi_lane_bit_packer.sv
// tb_multi_lane_bit_packer: bit-queue reference model with per-cycle compare plus directed literal checks
module tb_multi_lane_bit_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_valid = 1'b0, i_last = 1'b0, i_ready = 1'b1;
  logic [67:0] tok_data = '0;
  logic [11:0] tok_len = '0;
  logic o_ready, o_valid, o_last, o_inc;
  logic [63:0] o_data;
  logic [6:0] o_bits;
  logic [9:0] o_line_bits;
  int tests = 0, fails = 0;
  bit armed = 0;
  bit mq[$];
  int mline = 0;
  bit mflush = 0, mlive = 0;
  int nchunks = 0;
  bit last_seen = 0;
  logic [63:0] lg_data;
  int lg_bits, lg_line;
  bit lg_inc;

  multi_lane_bit_packer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_tok_data(tok_data), .i_tok_len(tok_len), .i_last(i_last),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_bits(o_bits),
    .o_last(o_last), .o_line_bits(o_line_bits), .o_incompressible(o_inc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void expect_now(output bit ev, output bit el, output bit er, output int eb,
                                     output logic [63:0] ed, output int eline, output bit einc);
    int n = mq.size();
    ev = n >= 64 || mflush;
    el = mflush && n <= 64;
    er = mlive && !mflush && n < 64;
    eb = ev ? (el ? n : 64) : 0;
    ed = '0;
    for (int i = 0; i < 64 && i < n; i++) ed[63-i] = mq[i];
    eline = el ? mline : 0;
`ifdef PACKER_INCOMPRESSIBLE_EN
    einc = el && mline > 16 * 32;
`else
    einc = 0;
`endif
  endfunction

  initial forever begin
    bit ev, el, er, einc;
    int eb, eline, sum, l;
    logic [63:0] ed;
    logic [33:0] d;
    @(posedge clk);
    expect_now(ev, el, er, eb, ed, eline, einc);
    if (!rst_n) begin
      mq.delete();
      mline = 0;
      mflush = 0;
      mlive = 0;
      armed = 1;
    end else begin
      if (i_valid && er) begin
        sum = 0;
        for (int k = 0; k < 2; k++) begin
          l = int'(tok_len[k*6 +: 6]);
          if (l > 34) l = 34;
          d = tok_data[k*34 +: 34];
          for (int b = l - 1; b >= 0; b--) mq.push_back(d[b]);
          sum += l;
        end
        mline = (mline + sum > 1023) ? 1023 : mline + sum;
        if (i_last) mflush = 1;
      end else if (ev && i_ready) begin
        if (el) begin
          mq.delete();
          mline = 0;
          mflush = 0;
        end else repeat (64) void'(mq.pop_front());
      end
      mlive = 1;
    end
  end

  initial forever begin
    bit ev, el, er, einc;
    int eb, eline;
    logic [63:0] ed;
    @(negedge clk);
    if (armed) begin
      expect_now(ev, el, er, eb, ed, eline, einc);
      chk("o_ready", 64'(o_ready), 64'(er));
      chk("o_valid", 64'(o_valid), 64'(ev));
      chk("o_bits", 64'(o_bits), 64'(eb));
      chk("o_last", 64'(o_last), 64'(el));
      chk("o_line_bits", 64'(o_line_bits), 64'(eline));
      chk("o_incompressible", 64'(o_inc), 64'(einc));
      if (ev) chk("o_data", o_data, ed);
      if (o_valid && i_ready) begin
        nchunks++;
        lg_data = o_data;
        lg_bits = int'(o_bits);
        lg_line = int'(o_line_bits);
        lg_inc = o_inc;
        if (o_last) last_seen = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [33:0] d0, input logic [5:0] l0, input logic [33:0] d1, input logic [5:0] l1, input logic last);
    bit acc = 0;
    tok_data = {d1, d0};
    tok_len = {l1, l0};
    i_last = last;
    i_valid = 1'b1;
    for (int t = 0; t < 100 && !acc; t++) begin
      acc = o_ready;
      tick();
    end
    i_valid = 1'b0;
    i_last = 1'b0;
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_last();
    for (int t = 0; t < 200 && !last_seen; t++) tick();
    chk("last_chunk_seen", 64'(last_seen), 64'd1);
  endtask

  localparam logic [33:0] ONES = '1;

  initial begin
    int c0;
    #2;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", 64'(o_ready), 64'd1);
    // full 68-bit beat: one full chunk, 4 bits remain
    send(ONES, 6'd34, ONES, 6'd34, 1'b0);
    chk("t2_valid", 64'(o_valid), 64'd1);
    chk("t2_data", o_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t2_ready", 64'(o_ready), 64'd0);
    tick();
    chk("t2_ready_after_pop", 64'(o_ready), 64'd1);
    chk("t2_valid_after_pop", 64'(o_valid), 64'd0);
    // backpressure with 72 bits buffered
    i_ready = 1'b0;
    send(ONES, 6'd34, ONES, 6'd34, 1'b0);
    repeat (3) begin
      chk("t4_valid_held", 64'(o_valid), 64'd1);
      chk("t4_data_held", o_data, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t4_bits_held", 64'(o_bits), 64'd64);
      chk("t4_ready_low", 64'(o_ready), 64'd0);
      tick();
    end
    i_ready = 1'b1;
    tick();
    last_seen = 0;
    send('0, 6'd0, '0, 6'd0, 1'b1);
    wait_last();
    chk("close_data", lg_data, 64'hFF00_0000_0000_0000);
    chk("close_bits", 64'(lg_bits), 64'd8);
    chk("close_line", 64'(lg_line), 64'd136);
    // reset mid-line discards buffered bits
    send(34'b10110, 6'd5, '0, 6'd0, 1'b0);
    rst_n = 1'b0;
    repeat (2) begin
      tick();
      chk("t1_valid", 64'(o_valid), 64'd0);
      chk("t1_data", o_data, 64'd0);
      chk("t1_ready", 64'(o_ready), 64'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("t1_ready_release", 64'(o_ready), 64'd1);
    last_seen = 0;
    send(34'b101, 6'd3, 34'b11, 6'd2, 1'b1);
    wait_last();
    chk("t3_data", lg_data, 64'hB800_0000_0000_0000);
    chk("t3_bits", 64'(lg_bits), 64'd5);
    chk("t3_line", 64'(lg_line), 64'd5);
    chk("t3_ready", 64'(o_ready), 64'd1);
    last_seen = 0;
    c0 = nchunks;
    send('0, 6'd0, '0, 6'd0, 1'b1);
    wait_last();
    chk("t5_chunks", 64'(nchunks - c0), 64'd1);
    chk("t5_bits", 64'(lg_bits), 64'd0);
    chk("t5_data", lg_data, 64'd0);
    chk("t5_line", 64'(lg_line), 64'd0);
    // clamp and mask: len 63 -> 34, lane1 keeps only its low 4 bits
    last_seen = 0;
    send(ONES, 6'd63, ONES, 6'd4, 1'b1);
    wait_last();
    chk("clamp_data", lg_data, 64'hFFFF_FFFF_FC00_0000);
    chk("clamp_bits", 64'(lg_bits), 64'd38);
    chk("clamp_line", 64'(lg_line), 64'd38);
    last_seen = 0;
    c0 = nchunks;
    for (int b = 0; b < 8; b++) send(ONES, 6'd34, ONES, 6'd34, b == 7);
    wait_last();
    chk("t6_chunks", 64'(nchunks - c0), 64'd9);
    chk("t6_bits", 64'(lg_bits), 64'd32);
    chk("t6_data", lg_data, 64'hFFFF_FFFF_0000_0000);
    chk("t6_line", 64'(lg_line), 64'd544);
`ifdef PACKER_INCOMPRESSIBLE_EN
    chk("t6_incompressible", 64'(lg_inc), 64'd1);
`else
    chk("t6_incompressible", 64'(lg_inc), 64'd0);
`endif
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1);
  end
endmodule
